// File: rtl/number_column_streamer.sv
// Streams a BCD number as 7-column font glyphs, most-significant digit first, one
// column per valid/ready handshake, with optional leading-zero blanking.
module number_column_streamer #(
    parameter int DIGITS = 4,
    parameter int COL_W  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [4*DIGITS-1:0]   value,
    input  logic                  blank_lz,
    input  logic                  col_ready,
    output logic                  col_valid,
    output logic [COL_W-1:0]      col_data,
    output logic                  col_last,
    output logic [3:0]            digit_idx,
    output logic                  busy,
    output logic                  done
);

    localparam int         VW      = 4 * DIGITS;
    localparam logic [3:0] TOP_DIG = 4'(DIGITS - 1);

    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_FIN} state_t;

    state_t          state;
    logic [VW-1:0]   val_q;
    logic            lz_q;
    logic [2:0]      col_cnt;

    logic [3:0]       cur_code, nxt_code, acc_code;
    logic             wrap, nxt_lz, nxt_blank, acc_blank, nxt_last;
    logic [2:0]       nxt_col;
    logic [3:0]       nxt_dig;
    logic [COL_W-1:0] nxt_data;

    // Glyph columns 1..5 packed MSB-first; columns 0 and 6 are always empty.
    function automatic logic [6:0] font_col(input logic [3:0] code, input logic [2:0] col);
        logic [39:0] g;
        logic [7:0]  b;
        case (code)
            4'd0:    g = 40'h3E_51_49_45_3E;
            4'd1:    g = 40'h00_42_7F_40_00;
            4'd2:    g = 40'h42_61_51_49_46;
            4'd3:    g = 40'h22_41_49_49_36;
            4'd4:    g = 40'h18_14_12_7F_10;
            4'd5:    g = 40'h27_45_45_45_39;
            4'd6:    g = 40'h3E_49_49_49_32;
            4'd7:    g = 40'h61_11_09_05_03;
            4'd8:    g = 40'h36_49_49_49_36;
            4'd9:    g = 40'h26_49_49_49_3E;
            default: g = 40'h0;
        endcase
        case (col)
            3'd1:    b = g[39:32];
            3'd2:    b = g[31:24];
            3'd3:    b = g[23:16];
            3'd4:    b = g[15:8];
            3'd5:    b = g[7:0];
            default: b = 8'h00;
        endcase
        return b[6:0];
    endfunction

    function automatic logic [COL_W-1:0] glyph_col(input logic [3:0] code, input logic blank,
                                                   input logic [2:0] col);
        logic [COL_W-1:0] r;
        r = '0;
        if (!blank)
            r[6:0] = font_col(code, col);
        return r;
    endfunction

    function automatic logic [3:0] digit_of(input logic [VW-1:0] v, input logic [3:0] d);
        logic [VW-1:0] s;
        s = v >> {d, 2'b00};
        return s[3:0];
    endfunction

    // Next-column values, registered on the handshake edge so col_data never glitches.
    always_comb begin
        cur_code  = digit_of(val_q, digit_idx);
        wrap      = (col_cnt == 3'd6);
        nxt_col   = wrap ? 3'd0 : col_cnt + 3'd1;
        nxt_dig   = wrap ? digit_idx - 4'd1 : digit_idx;
        nxt_lz    = wrap ? (lz_q && cur_code == 4'd0) : lz_q;
        nxt_code  = digit_of(val_q, nxt_dig);
        nxt_blank = nxt_lz && (nxt_code == 4'd0) && (nxt_dig != 4'd0);
        nxt_data  = glyph_col(nxt_code, nxt_blank, nxt_col);
        nxt_last  = (nxt_dig == 4'd0) && (nxt_col == 3'd6);
        acc_code  = digit_of(value, TOP_DIG);
        acc_blank = blank_lz && (acc_code == 4'd0) && (TOP_DIG != 4'd0);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            col_valid <= 1'b0;
            col_data  <= '0;
            col_last  <= 1'b0;
            digit_idx <= 4'd0;
            busy      <= 1'b0;
            done      <= 1'b0;
            col_cnt   <= 3'd0;
            lz_q      <= 1'b0;
        end else begin
            case (state)
                S_IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        val_q     <= value;
                        lz_q      <= blank_lz;
                        col_cnt   <= 3'd0;
                        digit_idx <= TOP_DIG;
                        col_data  <= glyph_col(acc_code, acc_blank, 3'd0);
                        col_last  <= 1'b0;
                        col_valid <= 1'b1;
                        busy      <= 1'b1;
                        state     <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (col_valid && col_ready) begin
                        if (col_last) begin
                            col_valid <= 1'b0;
                            col_last  <= 1'b0;
                            col_data  <= '0;
                            digit_idx <= 4'd0;
                            busy      <= 1'b0;
                            done      <= 1'b1;
                            state     <= S_FIN;
                        end else begin
                            col_cnt   <= nxt_col;
                            digit_idx <= nxt_dig;
                            lz_q      <= nxt_lz;
                            col_data  <= nxt_data;
                            col_last  <= nxt_last;
                        end
                    end
                end
                S_FIN: begin
                    done  <= 1'b0;
                    state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_number_column_streamer.sv
// Directed bench for number_column_streamer: glyph streams, blanking, backpressure, reset abort.
module tb_number_column_streamer;

    logic        clk = 1'b0;
    logic        rst, start, blank_lz, col_ready;
    logic [15:0] value;
    logic        col_valid, col_last, busy, done;
    logic [7:0]  col_data;
    logic [3:0]  digit_idx;

    number_column_streamer #(.DIGITS(4), .COL_W(8)) dut (
        .clk(clk), .rst(rst), .start(start), .value(value), .blank_lz(blank_lz),
        .col_ready(col_ready), .col_valid(col_valid), .col_data(col_data),
        .col_last(col_last), .digit_idx(digit_idx), .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    logic [7:0] font [10][5];
    logic [7:0] got_d[$];
    logic       got_l[$];
    logic [3:0] got_i[$];
    logic [7:0] exp_d[$];
    int         stall_viol;
    logic       done_busy, done_valid;
    bit         timed_out;

    task automatic build_exp(input logic [15:0] v, input logic [3:0] bmask);
        logic [3:0] code;
        logic [7:0] b;
        exp_d.delete();
        for (int d = 3; d >= 0; d--) begin
            code = v[4*d +: 4];
            for (int c = 0; c < 7; c++) begin
                b = 8'h00;
                if (!bmask[d] && code <= 4'd9 && c >= 1 && c <= 5)
                    b = font[code][c-1];
                exp_d.push_back(b);
            end
        end
    endtask

    task automatic do_start(input logic [15:0] v, input logic bz);
        @(negedge clk);
        value = v; blank_lz = bz; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    // mode 0: always ready; 1: 5-cycle stall then irregular ready; 2: ready plus mid-stream start/value change
    task automatic capture(input int mode, input int maxc);
        logic       rdy, stalled, pl;
        logic [7:0] pd;
        logic [3:0] pi;
        got_d.delete(); got_l.delete(); got_i.delete();
        stall_viol = 0; timed_out = 1; stalled = 0; pd = 0; pl = 0; pi = 0;
        for (int c = 0; c < maxc; c++) begin
            if (done === 1'b1) begin
                timed_out = 0; done_busy = busy; done_valid = col_valid;
                break;
            end
            if (stalled && (col_data !== pd || col_last !== pl || digit_idx !== pi))
                stall_viol++;
            rdy = 1'b1;
            if (mode == 1) rdy = !(c >= 3 && c < 8) && (c % 3 != 2);
            if (mode == 2) begin
                if (c == 5) begin start = 1'b1; value = 16'h9999; end
                if (c == 6) start = 1'b0;
            end
            col_ready = rdy;
            if (col_valid && rdy) begin
                got_d.push_back(col_data); got_l.push_back(col_last); got_i.push_back(digit_idx);
            end
            stalled = col_valid && !rdy; pd = col_data; pl = col_last; pi = digit_idx;
            @(negedge clk);
        end
    endtask

    task automatic check_stream(input string name);
        checks++;
        if (timed_out || got_d.size() != 28) begin
            failures++;
            $display("FAIL %s_count: got %0d handshakes (timeout=%0d), expected 28", name, got_d.size(), timed_out);
        end else begin
            for (int i = 0; i < 28; i++) begin
                checks++;
                if (got_d[i] !== exp_d[i] || got_l[i] !== (i == 27) || got_i[i] !== 4'(3 - i / 7)) begin
                    failures++;
                    $display("FAIL %s_col%0d: got data=%h last=%b dig=%0d, expected data=%h last=%b dig=%0d",
                             name, i, got_d[i], got_l[i], got_i[i], exp_d[i], (i == 27), 3 - i / 7);
                end
            end
        end
    endtask

    task automatic check_done(input string name);
        checks++;
        if (timed_out || done_busy !== 1'b0 || done_valid !== 1'b0) begin
            failures++;
            $display("FAIL %s_done: timeout=%0d busy=%b valid=%b, expected done with busy=0 valid=0",
                     name, timed_out, done_busy, done_valid);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL %s_done_pulse: done=%b busy=%b one cycle later, expected 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        @(negedge clk); @(negedge clk);
        checks++;
        if ({col_valid, col_data, col_last, digit_idx, busy, done} !== 16'h0) begin
            failures++;
            $display("FAIL reset: got valid=%b data=%h last=%b dig=%0d busy=%b done=%b, expected all 0",
                     col_valid, col_data, col_last, digit_idx, busy, done);
        end
        rst = 1'b0;
    endtask

    task automatic test_basic();
        do_start(16'h1208, 1'b0);
        checks++;
        if (col_valid !== 1'b1 || busy !== 1'b1 || digit_idx !== 4'd3 || col_data !== 8'h00) begin
            failures++;
            $display("FAIL basic_first: got valid=%b busy=%b dig=%0d data=%h, expected 1 1 3 00",
                     col_valid, busy, digit_idx, col_data);
        end
        capture(0, 200);
        build_exp(16'h1208, 4'b0000);
        check_stream("basic");
        checks++;
        if (got_d.size() > 3 && got_d[3] !== 8'h7F) begin
            failures++;
            $display("FAIL basic_one_col3: got %h expected 7f", got_d[3]);
        end
        check_done("basic");
    endtask

    task automatic test_leading_zero();
        do_start(16'h0042, 1'b1);
        capture(0, 200);
        build_exp(16'h0042, 4'b1100);
        check_stream("lz42");
        checks++;
        if (got_d.size() > 17 && got_d[17] !== 8'h12) begin
            failures++;
            $display("FAIL lz42_four_col3: got %h expected 12", got_d[17]);
        end
        check_done("lz42");
        do_start(16'h0000, 1'b1);
        capture(0, 200);
        build_exp(16'h0000, 4'b1110);
        check_stream("lz0");
        checks++;
        if (got_d.size() > 22 && got_d[22] !== 8'h3E) begin
            failures++;
            $display("FAIL lz0_zero_col1: got %h expected 3e", got_d[22]);
        end
        check_done("lz0");
    endtask

    task automatic test_backpressure();
        do_start(16'h1208, 1'b0);
        capture(1, 400);
        build_exp(16'h1208, 4'b0000);
        check_stream("bp");
        checks++;
        if (stall_viol != 0) begin
            failures++;
            $display("FAIL bp_stable: got %0d stalled-cycle changes, expected 0", stall_viol);
        end
        check_done("bp");
    endtask

    task automatic test_ignore_and_blank_code();
        do_start(16'h1208, 1'b0);
        capture(2, 200);
        build_exp(16'h1208, 4'b0000);
        check_stream("ignore");
        check_done("ignore");
        checks++;
        if (col_valid !== 1'b0 || busy !== 1'b0) begin
            failures++;
            $display("FAIL ignore_no_restart: got valid=%b busy=%b, expected 0 0", col_valid, busy);
        end
        do_start(16'hA123, 1'b0);
        capture(0, 200);
        build_exp(16'hA123, 4'b0000);
        check_stream("codeA");
        check_done("codeA");
    endtask

    task automatic test_reset_mid();
        int hs;
        int seen_done;
        do_start(16'h1208, 1'b0);
        col_ready = 1'b1;
        hs = 0;
        for (int c = 0; c < 100; c++) begin
            if (col_valid) begin
                hs++;
                if (hs == 10) begin rst = 1'b1; break; end
            end
            @(negedge clk);
        end
        @(negedge clk);
        checks++;
        if (hs != 10 || col_valid !== 1'b0 || busy !== 1'b0 || done !== 1'b0 || digit_idx !== 4'd0) begin
            failures++;
            $display("FAIL rst_mid: hs=%0d valid=%b busy=%b done=%b dig=%0d, expected 10 0 0 0 0",
                     hs, col_valid, busy, done, digit_idx);
        end
        rst = 1'b0;
        seen_done = 0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            if (done === 1'b1) seen_done++;
        end
        checks++;
        if (seen_done != 0) begin
            failures++;
            $display("FAIL rst_mid_no_done: got %0d done pulses, expected 0", seen_done);
        end
        do_start(16'h1208, 1'b0);
        checks++;
        if (col_valid !== 1'b1 || digit_idx !== 4'd3 || col_data !== 8'h00) begin
            failures++;
            $display("FAIL rst_restart: got valid=%b dig=%0d data=%h, expected 1 3 00", col_valid, digit_idx, col_data);
        end
        capture(0, 200);
        build_exp(16'h1208, 4'b0000);
        check_stream("restart");
        check_done("restart");
    endtask

    initial begin
        font[0] = '{8'h3E, 8'h51, 8'h49, 8'h45, 8'h3E};
        font[1] = '{8'h00, 8'h42, 8'h7F, 8'h40, 8'h00};
        font[2] = '{8'h42, 8'h61, 8'h51, 8'h49, 8'h46};
        font[3] = '{8'h22, 8'h41, 8'h49, 8'h49, 8'h36};
        font[4] = '{8'h18, 8'h14, 8'h12, 8'h7F, 8'h10};
        font[5] = '{8'h27, 8'h45, 8'h45, 8'h45, 8'h39};
        font[6] = '{8'h3E, 8'h49, 8'h49, 8'h49, 8'h32};
        font[7] = '{8'h61, 8'h11, 8'h09, 8'h05, 8'h03};
        font[8] = '{8'h36, 8'h49, 8'h49, 8'h49, 8'h36};
        font[9] = '{8'h26, 8'h49, 8'h49, 8'h49, 8'h3E};
        start = 1'b0; blank_lz = 1'b0; col_ready = 1'b0; value = 16'h0;
        test_reset();
        test_basic();
        test_leading_zero();
        test_backpressure();
        test_ignore_and_blank_code();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
